// File: rtl/alu_add_pkg.sv
// Shared definitions for the arbitrated 16-bit adder: flag bit positions,
// flag count and the response-buffer state encoding.
package alu_add_pkg;

   localparam int FLG_CY = 0;
   localparam int FLG_S  = 1;
   localparam int FLG_ZR = 2;
   localparam int FLG_P  = 3;
   localparam int FLG_V  = 4;
   localparam int NFLAGS = 5;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_add_arbiter_if.sv
// Request/response bundle between the client pipelines and the shared adder.
// master = client side, slave = arbiter side.
interface alu_add_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = $clog2(NREQ)
);
   import alu_add_pkg::*;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ*W-1:0] req_y;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_z;
   logic [NFLAGS-1:0] rsp_flags;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags
   );

endinterface

// File: rtl/alu_add_core.sv
// Purely combinational W-bit adder producing the sum and the five
// status flags {Overflow, Parity, Zero, Sign, Carry}.
module alu_add_core
   import alu_add_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]      x,
   input  logic [W-1:0]      y,
   output logic [W-1:0]      z,
   output logic [NFLAGS-1:0] flags
);

   // Even parity: 1 when the word holds an even number of ones.
   function automatic logic even_parity(input logic [W-1:0] v);
      return ~^v;
   endfunction

   logic [W:0] sum_s;

   // Widened add keeps the carry out; flags are derived from the sum.
   always_comb begin
      sum_s         = {1'b0, x} + {1'b0, y};
      z             = sum_s[W-1:0];
      flags         = {NFLAGS{1'b0}};
      flags[FLG_CY] = sum_s[W];
      flags[FLG_S]  = sum_s[W-1];
      flags[FLG_ZR] = (sum_s[W-1:0] == {W{1'b0}});
      flags[FLG_P]  = even_parity(sum_s[W-1:0]);
      flags[FLG_V]  = (x[W-1] == y[W-1]) && (sum_s[W-1] != x[W-1]);
   end

endmodule

// File: rtl/alu_add_arbiter.sv
// Round-robin arbiter in front of one shared adder with a one-entry
// registered response buffer. Build option ALU_ADD_ARB_PRIO_EN makes
// requester 0 strict-priority; the others keep round-robin among themselves.
module alu_add_arbiter
   import alu_add_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   alu_add_arbiter_if.slave bus
);

   state_e            state_q, state_d;
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [W-1:0]      rsp_z_q, rsp_z_d;
   logic [NFLAGS-1:0] rsp_flags_q, rsp_flags_d;

   logic              can_accept_s;
   logic              gnt_found_s;
   logic              hit_s;
   logic [IDW-1:0]    gnt_idx_s;
   logic [NREQ-1:0]   ready_s;
   logic [W-1:0]      gnt_x_s, gnt_y_s;
   logic [W-1:0]      core_z_s;
   logic [NFLAGS-1:0] core_flags_s;

   // (base + k) mod NREQ, for the wrapping search and pointer advance.
   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
      int sum_v;
      sum_v = int'(base) + k;
      return IDW'(sum_v % NREQ);
   endfunction

   // Grant: first valid requester at or after rr_ptr; nothing while the buffer
   // is blocked or reset is active, so no request slips in during reset.
   always_comb begin
      can_accept_s = !rst && ((state_q == ST_EMPTY) || bus.rsp_ready);
      gnt_idx_s    = {IDW{1'b0}};
      hit_s        = 1'b0;
`ifdef ALU_ADD_ARB_PRIO_EN
      gnt_found_s  = can_accept_s && bus.req_valid[0];
      for (int k = 0; k < NREQ; k++) begin
         hit_s       = can_accept_s && !gnt_found_s &&
                       (wrap_idx(rr_ptr_q, k) != {IDW{1'b0}}) &&
                       bus.req_valid[wrap_idx(rr_ptr_q, k)];
         gnt_idx_s   = hit_s ? wrap_idx(rr_ptr_q, k) : gnt_idx_s;
         gnt_found_s = gnt_found_s | hit_s;
      end
`else
      gnt_found_s  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         hit_s       = can_accept_s && !gnt_found_s && bus.req_valid[wrap_idx(rr_ptr_q, k)];
         gnt_idx_s   = hit_s ? wrap_idx(rr_ptr_q, k) : gnt_idx_s;
         gnt_found_s = gnt_found_s | hit_s;
      end
`endif
      ready_s = gnt_found_s ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s) : {NREQ{1'b0}};
   end

   // Steer the winner's operands into the shared adder.
   always_comb begin
      gnt_x_s = bus.req_x[int'(gnt_idx_s)*W +: W];
      gnt_y_s = bus.req_y[int'(gnt_idx_s)*W +: W];
   end

   alu_add_core #(.W(W)) u_core (
      .x     (gnt_x_s),
      .y     (gnt_y_s),
      .z     (core_z_s),
      .flags (core_flags_s)
   );

   // Buffer FSM and response load; drain and load may share one edge.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_id_d    = rsp_id_q;
      rsp_z_d     = rsp_z_q;
      rsp_flags_d = rsp_flags_q;
      case (state_q)
         ST_EMPTY: state_d = gnt_found_s ? ST_FULL : ST_EMPTY;
         ST_FULL:  state_d = (bus.rsp_ready && !gnt_found_s) ? ST_EMPTY : ST_FULL;
         default:  state_d = ST_EMPTY;
      endcase
      if (gnt_found_s) begin
         rsp_id_d    = gnt_idx_s;
         rsp_z_d     = core_z_s;
         rsp_flags_d = core_flags_s;
`ifdef ALU_ADD_ARB_PRIO_EN
         rr_ptr_d    = (gnt_idx_s == {IDW{1'b0}}) ? rr_ptr_q : wrap_idx(gnt_idx_s, 1);
`else
         rr_ptr_d    = wrap_idx(gnt_idx_s, 1);
`endif
      end else begin
         rr_ptr_d    = rr_ptr_q;
      end
   end

   // State, pointer and response registers; reset discards any buffered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         rr_ptr_q    <= {IDW{1'b0}};
         rsp_id_q    <= {IDW{1'b0}};
         rsp_z_q     <= {W{1'b0}};
         rsp_flags_q <= {NFLAGS{1'b0}};
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_id_q    <= rsp_id_d;
         rsp_z_q     <= rsp_z_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.rsp_valid = (state_q == ST_FULL);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_z     = rsp_z_q;
   assign bus.rsp_flags = rsp_flags_q;

endmodule

// File: doc/alu_add_arbiter.md
# alu_add_arbiter

Shares a single 16-bit addition datapath with full flag generation among NREQ requesters. Requests arrive on independent valid/ready channels, and the block arbitrates them round-robin. The winning operands go through the adder, and the sum is returned with its flags and the requester ID in a one-entry registered response buffer. The block sits between the client pipelines and the adder, so clients never drive the adder directly.

## Interface
- NREQ, 4: number of requesters (2..8).
- W, 16: operand and result width.
- IDW, $clog2(NREQ): width of the requester ID.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_x  in  NREQ*W  X operands; requester i uses [i*W +: W].
- req_y  in  NREQ*W  Y operands; same packing as req_x.
- rsp_valid  out  1  the response buffer holds a result.
- rsp_ready  in  1  the consumer takes the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_z  out  W  sum X+Y modulo 2^W.
- rsp_flags  out  5  flags {Overflow, Parity, Zero, Sign, Carry}, bit 4 down to bit 0.

## Operation
- Flags:
  - Carry: carry out of bit W-1.
  - Sign: Z[W-1].
  - Zero: Z==0.
  - Parity: ~^Z, so 1 when Z has an even number of ones.
  - Overflow: X[W-1]==Y[W-1] and Z[W-1]!=X[W-1].
- State machine has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1; the buffer contents are stable.
- The buffer can accept a request when state is EMPTY, or when state is FULL and rsp_ready=1 (pass-through drain).
- Grant: if the buffer can accept and any req_valid is high, the first valid requester at or after rr_ptr (searching upward, wrapping) wins. Its req_ready goes high combinationally; all other req_ready bits stay 0.
- Handshake: a request is accepted when req_valid[i] & req_ready[i]. At the next edge the buffer loads {i, Z, flags}, state becomes FULL, and rr_ptr becomes (i+1) mod NREQ.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + rsp_ready + accept -> FULL with the new contents, so back-to-back throughput is 1 per cycle.
  - FULL + rsp_ready + no accept -> EMPTY.
  - FULL + !rsp_ready -> FULL; hold, all req_ready=0.
- rr_ptr changes only on acceptance.
- A requester may drop req_valid before it is granted. Its operands must stay stable while req_valid is high.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_z=0, rsp_flags=0, state=EMPTY, rr_ptr=0, req_ready=0.
- req_ready depends combinationally on req_valid, rsp_ready, state and rr_ptr. It does not depend on any operand.
- Latency: a request accepted in cycle t has its response visible in cycle t+1.
- Throughput: 1 result per cycle with rsp_ready held high.
- Simultaneous drain and accept in the same cycle: the old response is consumed and the new one is loaded at the same edge. No bubble, no loss.
- Reset asserted mid-operation: the buffered response is discarded immediately and asynchronously. Requests outstanding during reset are not accepted.
- After reset is released, requester 0 has first priority.
- Starvation bound: a continuously valid requester is granted within NREQ accepts.

## Configuration
- ALU_ADD_ARB_PRIO_EN defined:
  - Requester 0 is strict-priority. Whenever req_valid[0]=1 and the buffer can accept, requester 0 wins.
  - Requesters 1..NREQ-1 arbitrate round-robin among themselves. rr_ptr is not updated by requester-0 grants.
- ALU_ADD_ARB_PRIO_EN undefined: pure round-robin over all NREQ requesters, as described above.

## Structure
- Package alu_add_pkg holds:
  - flag bit indices: FLG_CY=0, FLG_S=1, FLG_ZR=2, FLG_P=3, FLG_V=4;
  - the flag count NFLAGS=5;
  - state encoding: ST_EMPTY=0, ST_FULL=1.
- Sub-module alu_add_core: combinational, parameter W, inputs X and Y, outputs Z and the five flags. It is instantiated once on the granted operands.
- The arbiter itself holds the grant logic, rr_ptr, the FSM and the response registers.

## Test plan
- Single request, req 0, X=8fff Y=8000 -> next cycle rsp_id=0, Z=0fff, flags CY=1 S=0 ZR=0 P=1 V=1.
- req 2, X=fffe Y=0002 -> Z=0000, CY=1 ZR=1 P=1 S=0 V=0. Then req 1, X=4000 Y=4000 -> Z=8000, S=1 V=1 P=0 CY=0 ZR=0.
- All 4 requesters valid continuously, rsp_ready=1, operands aaaa+5555 -> grant order 0,1,2,3,0 on consecutive cycles. Each response has Z=ffff, S=1, P=1, CY=0, V=0.
- Backpressure: rsp_ready=0 for 3 cycles with FULL -> rsp_* stable and all req_ready=0. Raising rsp_ready with a request pending -> drain and load on the same edge, with no lost or duplicated response.
- Assert rst mid-stream with FULL -> rsp_valid=0 and all outputs 0 immediately. After release, with all requests valid, the first grant goes to requester 0.
- With ALU_ADD_ARB_PRIO_EN: req 0 and req 3 valid continuously -> req 0 wins every cycle. When req 0 drops, req 3 is granted next cycle.
